// File: rtl/instr_fetch_unit.sv
// Prefetch stage: fetches words over a req/ack memory port into a small FIFO of {pc, word}
// and hands them to the datapath; redirects flush the FIFO and restart fetch at the target.
module instr_fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     mem_req,
   output logic [31:0]              mem_addr,
   input  logic                     mem_ack,
   input  logic [31:0]              mem_rdata,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   output logic                     inst_valid,
   input  logic                     inst_ready,
   output logic [31:0]              inst,
   output logic [31:0]              inst_pc,
   output logic [31:0]              inst_pc4,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, REQ, DROP} stateT;

   stateT            state, nextState;
   logic [31:0]      fetchPc, reqAddr, nextReqAddr, newPc;
   logic [PW-1:0]    headPtr, tailPtr;
   logic [CW-1:0]    count, nextCount;
   logic [31:0]      pcMem   [DEPTH];
   logic [31:0]      wordMem [DEPTH];
   logic             doPush, doPop, roomNext;
   logic             unusedPcBits;

   assign unusedPcBits = ^redirect_pc[1:0];
   assign newPc        = {redirect_pc[31:2], 2'b00};

   // A redirect squashes both the push of an acked word and any same-cycle pop.
   assign doPush = (state == REQ) && mem_ack && !redirect;
   assign doPop  = (count != '0) && inst_ready && !redirect;

   always_comb begin
      nextCount = count;
      if (redirect)
         nextCount = '0;
      else if (doPush && !doPop)
         nextCount = count + CW'(1);
      else if (!doPush && doPop)
         nextCount = count - CW'(1);
   end

   assign roomNext = nextCount < CW'(DEPTH);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= nextState;
   end

   always_comb begin
      nextState   = state;
      nextReqAddr = reqAddr;
      case (state)
         IDLE: begin
            if (redirect) begin
               nextState   = REQ;
               nextReqAddr = newPc;
            end else if (roomNext) begin
               nextState   = REQ;
               nextReqAddr = fetchPc;
            end
         end
         REQ: begin
            if (redirect) begin
               if (mem_ack) begin
                  nextState   = REQ;
                  nextReqAddr = newPc;
               end else begin
                  nextState   = DROP;
               end
            end else if (mem_ack) begin
               if (roomNext) begin
                  nextState   = REQ;
                  nextReqAddr = fetchPc + 32'd4;
               end else begin
                  nextState   = IDLE;
               end
            end
         end
         DROP: begin
            // The stale request stays on the bus until its ack retires it.
            if (mem_ack) begin
               nextState   = REQ;
               nextReqAddr = redirect ? newPc : fetchPc;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      mem_req    = (state != IDLE);
      mem_addr   = reqAddr;
      inst_valid = (count != '0);
      inst       = inst_valid ? wordMem[headPtr] : 32'h0;
      inst_pc    = inst_valid ? pcMem[headPtr]   : 32'h0;
      inst_pc4   = inst_pc + 32'd4;
      occupancy  = count;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reqAddr <= RESET_PC;
         fetchPc <= RESET_PC;
         headPtr <= '0;
         tailPtr <= '0;
         count   <= '0;
      end else begin
         reqAddr <= nextReqAddr;
         count   <= nextCount;
         if (redirect) begin
            fetchPc <= newPc;
            headPtr <= '0;
            tailPtr <= '0;
         end else begin
            if (doPush) begin
               fetchPc <= fetchPc + 32'd4;
               tailPtr <= tailPtr + PW'(1);
            end
            if (doPop)
               headPtr <= headPtr + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) begin
         pcMem[tailPtr]   <= reqAddr;
         wordMem[tailPtr] <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-programmable memory that returns addr ^ 0xDEAD0000.
module tb_instr_fetch_unit;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_req, mem_ack;
   logic [31:0] mem_addr, mem_rdata;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst, inst_pc, inst_pc4;
   logic [$clog2(DEPTH):0] occupancy;

   int ackLat  = 0;
   int waitCnt = 0;
   int checks  = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst(inst), .inst_pc(inst_pc), .inst_pc4(inst_pc4), .occupancy(occupancy)
   );

   // Memory: ack arrives once a request has been held for ackLat cycles.
   always @(posedge clk) begin
      if (!mem_req || mem_ack) waitCnt <= 0;
      else                     waitCnt <= waitCnt + 1;
   end
   assign mem_ack   = mem_req && (waitCnt >= ackLat);
   assign mem_rdata = mem_addr ^ 32'hDEAD_0000;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkVal({tag, "_req"},   32'(mem_req),    32'h0);
      checkVal({tag, "_addr"},  mem_addr,        32'h0);
      checkVal({tag, "_valid"}, 32'(inst_valid), 32'h0);
      checkVal({tag, "_inst"},  inst,            32'h0);
      checkVal({tag, "_pc"},    inst_pc,         32'h0);
      checkVal({tag, "_pc4"},   inst_pc4,        32'h4);
      checkVal({tag, "_occ"},   32'(occupancy),  32'h0);
   endtask

   // Leaves rst deasserted 1 time unit after a rising edge; the next edge is cycle 1.
   task automatic doReset();
      rst      = 1'b0;
      redirect = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
   endtask

   initial begin
      // Reset values and streaming with a zero-wait memory
      ackLat = 0; inst_ready = 1'b1;
      rst = 1'b0;
      repeat (2) tick();
      checkResetOutputs("rst");
      rst = 1'b1;
      tick();
      checkVal("c1_req",  32'(mem_req), 32'h1);
      checkVal("c1_addr", mem_addr,     32'h0);
      tick();
      for (int i = 0; i < 4; i++) begin
         checkVal("str_valid", 32'(inst_valid), 32'h1);
         checkVal("str_pc",    inst_pc,  32'(i * 4));
         checkVal("str_pc4",   inst_pc4, 32'(i * 4 + 4));
         checkVal("str_inst",  inst,     32'(i * 4) ^ 32'hDEAD_0000);
         tick();
      end

      // Fill to DEPTH with no consumer, then one pop allows exactly one more fetch
      inst_ready = 1'b0; ackLat = 0;
      doReset();
      repeat (5) tick();
      checkVal("full_req",   32'(mem_req),   32'h0);
      checkVal("full_occ",   32'(occupancy), 32'h4);
      checkVal("full_pc",    inst_pc,        32'h0);
      tick();
      checkVal("full_hold",  32'(mem_req),   32'h0);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      checkVal("pop_occ",    32'(occupancy), 32'h3);
      checkVal("pop_req",    32'(mem_req),   32'h1);
      checkVal("pop_addr",   mem_addr,       32'h10);
      checkVal("pop_pc",     inst_pc,        32'h4);
      tick();
      checkVal("refill_occ", 32'(occupancy), 32'h4);
      checkVal("refill_req", 32'(mem_req),   32'h0);
      tick();
      checkVal("refill_idle", 32'(mem_req),  32'h0);

      // Redirect while a slow request is outstanding
      ackLat = 3; inst_ready = 1'b1;
      doReset();
      tick();
      tick();
      redirect = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      checkVal("drop_req",   32'(mem_req),    32'h1);
      checkVal("drop_addr",  mem_addr,        32'h0);
      checkVal("drop_valid", 32'(inst_valid), 32'h0);
      tick();
      checkVal("drop_hold",  mem_addr,        32'h0);
      tick();
      checkVal("rd_addr",    mem_addr,        32'h100);
      checkVal("rd_occ",     32'(occupancy),  32'h0);
      for (int i = 0; i < 10 && !inst_valid; i++) tick();
      checkVal("rd_valid",   32'(inst_valid), 32'h1);
      checkVal("rd_pc",      inst_pc,         32'h100);
      checkVal("rd_inst",    inst,            32'h100 ^ 32'hDEAD_0000);

      // Redirect coincident with ack and pop; unaligned target
      ackLat = 0; inst_ready = 1'b1;
      doReset();
      repeat (4) tick();
      checkVal("co_pre",     32'(inst_valid), 32'h1);
      redirect = 1'b1; redirect_pc = 32'h203;
      tick();
      redirect = 1'b0;
      checkVal("co_valid",   32'(inst_valid), 32'h0);
      checkVal("co_occ",     32'(occupancy),  32'h0);
      checkVal("co_req",     32'(mem_req),    32'h1);
      checkVal("co_addr",    mem_addr,        32'h200);
      tick();
      checkVal("co_pc",      inst_pc,         32'h200);
      checkVal("co_inst",    inst,            32'h200 ^ 32'hDEAD_0000);
      checkVal("co_occ1",    32'(occupancy),  32'h1);

      // Wrap at the top of the address space
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      checkVal("wr_addr",    mem_addr,        32'hFFFF_FFFC);
      checkVal("wr_valid",   32'(inst_valid), 32'h0);
      tick();
      checkVal("wr_pc",      inst_pc,         32'hFFFF_FFFC);
      checkVal("wr_pc4",     inst_pc4,        32'h0);
      tick();
      checkVal("wr_pc_b",    inst_pc,         32'h0);
      checkVal("wr_pc4_b",   inst_pc4,        32'h4);
      checkVal("wr_inst_b",  inst,            32'hDEAD_0000);

      // Asynchronous reset mid-stream with three entries buffered
      ackLat = 0; inst_ready = 1'b0;
      doReset();
      repeat (4) tick();
      checkVal("mid_occ",    32'(occupancy),  32'h3);
      #2;
      rst = 1'b0;
      #1;
      checkResetOutputs("async");
      tick();
      rst = 1'b1;
      inst_ready = 1'b1;
      tick();
      checkVal("rs_req",     32'(mem_req),    32'h1);
      checkVal("rs_addr",    mem_addr,        32'h0);
      tick();
      checkVal("rs_valid",   32'(inst_valid), 32'h1);
      checkVal("rs_pc",      inst_pc,         32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Upstream fetch stage for the MIPS datapath. It fetches 32-bit instructions from a variable-latency instruction memory over a req/ack handshake and buffers them in a small prefetch FIFO. It presents each instruction, its PC and PC+4 to the datapath with valid/ready. It also accepts branch, jump and jr redirects, which flush the buffer and restart fetch at the new target.

## Interface
- DEPTH, 4: prefetch FIFO entries (power of two, ≥2)
- RESET_PC, 32'h00000000: first fetch address after reset
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous and active-low
- mem_req  out  1  fetch request to instruction memory
- mem_addr  out  32  word-aligned fetch address, stable while mem_req=1
- mem_ack  in  1  memory response; mem_rdata valid in same cycle
- mem_rdata  in  32  fetched instruction word
- redirect  in  1  datapath PC override (taken branch/jump/jr)
- redirect_pc  in  32  new fetch address; bits [1:0] forced to 0
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  datapath consumes head when inst_valid=1
- inst  out  32  head instruction (0 when empty)
- inst_pc  out  32  head PC (0 when empty)
- inst_pc4  out  32  inst_pc + 4, modulo 2^32
- occupancy  out  clog2(DEPTH)+1  valid FIFO entries

## Operation
- State: fetch_pc, req_addr, FIFO of {pc, word}, FSM IDLE / REQ / DROP.
- One outstanding request max; mem_addr = req_addr.
- IDLE: mem_req=0. Go REQ, latching req_addr=fetch_pc, when next-cycle occupancy < DEPTH.
- REQ: mem_req=1. On mem_ack: push {req_addr, mem_rdata}, fetch_pc += 4. Stay in REQ with req_addr = new fetch_pc if post-push/pop occupancy < DEPTH, else IDLE.
- DROP: mem_req=1 at stale req_addr until mem_ack; the response is discarded, not pushed. Then REQ at fetch_pc.
- Pop: inst_valid & inst_ready; head advances. Push and pop in the same cycle leaves occupancy unchanged.
- Full: no new request is issued while occupancy = DEPTH. A pop in the same cycle counts, so a request is allowed next cycle.
- Redirect has priority over everything:
  - FIFO cleared and occupancy=0 next cycle; a same-cycle pop is ignored.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - REQ without ack → DROP.
  - REQ with ack, or IDLE → REQ at the new pc next cycle; the acked data is discarded.
  - DROP → stay in DROP, updating fetch_pc only.
- fetch_pc and PC+4 wrap at 2^32.
- mem_ack outside REQ/DROP is ignored.

## Timing
- Reset (async assert, sync effect from deassert):
  - mem_req=0, mem_addr=RESET_PC, FSM=IDLE.
  - inst_valid=0, inst=0, inst_pc=0, inst_pc4=4, occupancy=0.
- First mem_req: first rising edge after rst deasserts → mem_req=1 in cycle 1.
- Fetch latency: mem_ack in cycle N → inst_valid=1 in cycle N+1.
- Zero-wait memory (ack tied high) with inst_ready=1 sustains one instruction per cycle.
- Redirect in cycle N:
  - inst_valid=0 in N+1.
  - New-pc request in N+1 (from IDLE/REQ) or the cycle after the stale ack (from DROP).
- All outputs are registered or decoded from registered state. There are no combinational paths from mem_ack, redirect or inst_ready to outputs, except the FIFO head update at the clock edge.
- rst asserted mid-request drops the outstanding request. After reset the memory must not deliver a stale mem_ack; that is the integration contract.

## Test plan
- Reset then ack tied 1, inst_ready=1 → inst_pc sequence 0,4,8,12 on consecutive cycles from cycle 2; inst_pc4 = inst_pc+4.
- inst_ready=0, ack 1 → exactly 4 pushes, then mem_req=0 and occupancy=4. Raise inst_ready for one cycle → one pop, then one new request at 0x10.
- Ack latency 3 cycles, redirect to 0x100 while waiting:
  - mem_req stays at the old address until ack; that word is not delivered.
  - Next mem_addr=0x100; first delivered inst_pc=0x100.
- redirect_pc=0x203 coincident with mem_ack and pop → FIFO empties; next mem_addr=0x200; acked word dropped.
- Redirect to 0xFFFFFFFC, ack 1 → inst_pc 0xFFFFFFFC then 0x00000000; inst_pc4 of first = 0.
- rst pulsed low mid-stream with occupancy=3 → all outputs return to reset values immediately; fetch restarts at RESET_PC.
